// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 scheduled demultiplexer: state encoding,
// default widths and the destination decoder.
package demux_pkg;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    function automatic logic [1:0] dest_onehot(input logic dest);
        return dest ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dlv_counter.sv
// Wrapping per-port delivery counter; a clear takes priority over an increment.
module dlv_counter
    import demux_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1x2_sched.sv
// One-entry buffered 1-to-2 demultiplexer: words are steered by in_dest or
// round-robin, held until the addressed port takes them, and counted per port.
module demux_1x2_sched
    import demux_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_dest,
    output logic [1:0]    y_valid,
    input  logic [1:0]    y_ready,
    output logic [W-1:0]  y_data,
    input  logic          clr_cnt,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [0:0]   state;
    logic [0:0]   state_nxt;
    logic         dest;
    logic         rr_ptr;
    logic [W-1:0] data_q;
    logic         accept;
    logic         delivery;

    // A delivery frees the buffer in the same cycle, so a new word can be
    // accepted behind it without a bubble.
    always_comb begin
        delivery = (state == HOLD) & y_ready[dest];
        in_ready = ~rst & ((state == IDLE) | delivery);
        accept   = in_valid & in_ready;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = HOLD;
        end else if (delivery) begin
            state_nxt = IDLE;
        end
    end

    // mode and in_dest only matter at the moment a word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            dest   <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q <= in_data;
                dest   <= mode ? rr_ptr : in_dest;
                if (mode) begin
                    rr_ptr <= ~rr_ptr;
                end
            end
        end
    end

    always_comb begin
        y_valid = (state == HOLD) ? dest_onehot(dest) : 2'b00;
        y_data  = data_q;
    end

    dlv_counter #(.CW(CW)) u_cnt0 (
        .clk (clk),
        .rst (rst),
        .inc (delivery & ~dest),
        .clr (clr_cnt),
        .cnt (cnt0)
    );

    dlv_counter #(.CW(CW)) u_cnt1 (
        .clk (clk),
        .rst (rst),
        .inc (delivery & dest),
        .clr (clr_cnt),
        .cnt (cnt1)
    );

    a_valid_onehot0 : assert property (@(posedge clk) disable iff (rst)
        !(y_valid[0] && y_valid[1]));

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (state == HOLD && !delivery) |=> (y_data == $past(y_data) && y_valid == $past(y_valid)));

endmodule

// File: doc/demux_1x2_sched.md
DEMUX_1X2_SCHED -- requirements
Module: demux_1x2_sched

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter CW, default 8, meaning per-port delivery counter width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port mode  input  1  0 = route by in_dest, 1 = round-robin.
REQ-006 The block SHALL have port in_valid  input  1  upstream word available.
REQ-007 The block SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-008 The block SHALL have port in_data  input  W  upstream word.
REQ-009 The block SHALL have port in_dest  input  1  destination port when mode=0.
REQ-010 The block SHALL have port y_valid  output  2  per-port valid; bit n addresses output port n.
REQ-011 The block SHALL have port y_ready  input  2  per-port downstream ready.
REQ-012 The block SHALL have port y_data  output  W  held word, shared by both ports.
REQ-013 The block SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-014 The block SHALL have port cnt0 / cnt1  output  CW each  words delivered on port 0 / port 1.

Function
REQ-015 The FSM SHALL have two states: IDLE (buffer empty) and HOLD (one word held in the buffer).
REQ-016 An accept SHALL occur when in_valid & in_ready are both high; a delivery SHALL occur when y_valid[dest] & y_ready[dest] are both high.
REQ-017 in_ready SHALL equal (state==IDLE) | delivery, giving single-cycle pass-through and one word per cycle at full throughput.
REQ-018 On accept, the block SHALL capture in_data into y_data and set dest = (mode ? rr_ptr : in_dest); the next state SHALL be HOLD.
REQ-019 In HOLD, y_valid SHALL be one-hot on dest; y_valid and y_data SHALL stay stable until delivery.
REQ-020 On a delivery without a simultaneous accept, the FSM SHALL go HOLD to IDLE; on a delivery with a simultaneous accept, the FSM SHALL stay in HOLD with the new word and dest.
REQ-021 The first word SHALL appear on y_valid one cycle after its accept (latency 1).
REQ-022 y_ready on the non-dest port SHALL be ignored; the two y_valid bits SHALL never be high together.
REQ-023 rr_ptr SHALL toggle on every accept made while mode=1, and SHALL hold its value while mode=0.
REQ-024 mode and in_dest SHALL be sampled only at accept; a change during HOLD SHALL not redirect the held word.
REQ-025 cnt0 / cnt1 SHALL increment by 1 on each delivery to port 0 / 1, wrapping from 2^CW-1 to 0.
REQ-026 When clr_cnt coincides with a delivery, the clear SHALL win and both counters SHALL become 0.
REQ-027 y_data SHALL be 0 in IDLE after reset and SHALL retain the last word after a delivery.

Reset
REQ-028 While rst=1, the block SHALL force state=IDLE, rr_ptr=0, dest=0, y_valid=2'b00, y_data=0, cnt0=cnt1=0; in_ready SHALL be 0 while rst is high.
REQ-029 An assertion of rst during HOLD SHALL discard the held word with no delivery and no count change.
REQ-030 After rst deasserts, the block SHALL be able to make its first accept on the next rising edge.

Structure
REQ-031 The package demux_pkg SHALL hold the state encoding (IDLE=0, HOLD=1) and the W and CW defaults.
REQ-032 Each delivery counter SHALL be one instance of the sub-module dlv_counter (inc, clr, async rst, CW-bit wrapping output), instantiated twice.

Verification
REQ-033 The bench SHALL cover: after rst, mode=0, in_dest=1, in_data=8'hA5, y_ready=2'b10 -> y_valid=2'b10 and y_data=A5 one cycle later, then cnt1=1 and cnt0=0.
REQ-034 The bench SHALL cover: mode=1, four back-to-back words 01,02,03,04, y_ready=2'b11 -> deliveries to ports 0,1,0,1 on consecutive cycles, in_ready held high, and cnt0=cnt1=2.
REQ-035 The bench SHALL cover: held word to port 0 with y_ready=2'b10 for 3 cycles -> y_valid=2'b01 and y_data stable, in_ready=0, with no count change.
REQ-036 The bench SHALL cover: cnt0=255 plus one delivery to port 0 -> cnt0=0; clr_cnt coinciding with a delivery -> both counters 0.
REQ-037 The bench SHALL cover: rst asserted mid-HOLD (y_valid=2'b01) -> y_valid=00 and counts 0 immediately, without waiting for a clock edge.
REQ-038 The bench SHALL cover: mode toggled 0 to 1 during HOLD -> the held word goes to its original dest, and rr_ptr stays unchanged until the next accept.
